rs232in_fifo: RTL and testbench



---
 rtl/rs232in_fifo.sv | 257 +++++++++++++++++++++++++
 tb/tb_rs232in_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232in_fifo.sv
// RS-232 receiver: 16x oversampling with 3-sample majority vote, configurable frame format,
// per-frame parity/framing/break flags and a first-word-fall-through receive FIFO.
module rs232in_fifo #(
  parameter int FREQUENCY = 25_000_000,
  parameter int BPS       = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk25MHz,
  input  logic                 reset_n,
  input  logic                 serial_rxd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 rx_busy
);

  localparam int DIV   = (FREQUENCY + 8 * BPS) / (16 * BPS);
  localparam int PW    = $clog2(DIV + 1);
  localparam int EW    = DATA_BITS + 3;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PTRW  = FIFO_LOG2 + 1;

  if (DIV < 2) begin : g_div_check
    $error("rs232in_fifo: clock divider DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY == 1) begin
      parity_err = ~x;
    end else if (PARITY == 2) begin
      parity_err = x;
    end else begin
      parity_err = 1'b0;
    end
  endfunction

  logic                 sync1_q, rxs_q, rxs_prev_q;
  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [3:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 samp7_q, samp7_d, samp8_q, samp8_d;
  logic                 tick_s, start_edge_s, eval_s, bit_s, push_s;
  logic [EW-1:0]        entry_s, head_s;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 overrun_q, overrun_d;
  logic                 empty_s, full_s, pop_s, wr_en_s, drop_s;

  assign tick_s       = (presc_q == PW'(DIV - 1));
  assign start_edge_s = (state_q == ST_IDLE) & rxs_prev_q & ~rxs_q;
  assign eval_s       = tick_s & (tick_q == 4'd9);
  assign bit_s        = maj3(samp7_q, samp8_q, rxs_q);

  // Two-flop synchroniser plus the delayed copy used for start-edge detection
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= serial_rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Prescaler and per-bit tick counter, both realigned to the start edge
  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    samp7_d = (tick_s && (tick_q == 4'd7)) ? rxs_q : samp7_q;
    samp8_d = (tick_s && (tick_q == 4'd8)) ? rxs_q : samp8_q;
    if (start_edge_s) begin
      presc_d = {PW{1'b0}};
      tick_d  = 4'd0;
    end else if (tick_s) begin
      presc_d = {PW{1'b0}};
      tick_d  = tick_q + 4'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = tick_q;
    end
  end

  // Frame state machine: next state, shift register, flags and push strobe
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_START;
          bit_d   = 4'd0;
          stop_d  = 1'b0;
          par_d   = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (eval_s) begin
          state_d = bit_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (eval_s) begin
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = 4'd0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (eval_s) begin
          par_d   = bit_s;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (eval_s) begin
          ferr_d = ferr_q | ~bit_s;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d  = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame receiver registers
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      presc_q <= {PW{1'b0}};
      tick_q  <= 4'd0;
      bit_q   <= 4'd0;
      stop_q  <= 1'b0;
      shift_q <= {DATA_BITS{1'b0}};
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      samp7_q <= 1'b1;
      samp8_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      samp7_q <= samp7_d;
      samp8_q <= samp8_d;
    end
  end

  // Without a parity bit par_q stays 0, so break only needs zero data and a framing error.
  assign entry_s = {(shift_q == {DATA_BITS{1'b0}}) & ~par_q & ferr_d,
                    ferr_d, parity_err(shift_q, par_q), shift_q};

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign pop_s   = ~empty_s & out_ready;
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // FIFO pointer and sticky overrun next-state; a drop outranks a clear
  always_comb begin
    wr_ptr_d  = wr_en_s ? (wr_ptr_q + PTRW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTRW'(1)) : rd_ptr_q;
    overrun_d = overrun_q;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= {PTRW{1'b0}};
      rd_ptr_q  <= {PTRW{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents are only visible through the empty-gated head
  always_ff @(posedge clk25MHz) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= entry_s;
    end
  end

  assign head_s = empty_s ? {EW{1'b0}} : mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

  assign out_valid                                        = ~empty_s;
  assign {break_detect, framing_error, parity_error, data} = head_s;
  assign overrun                                          = overrun_q;
  assign rx_busy                                          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs232in_fifo.sv
// Bench for rs232in_fifo: an 8N1 instance and a 7E1 instance driven with serial frames,
// checked against a queue-based model of the expected FIFO entries.
`timescale 1ns/1ps
module tb_rs232in_fifo;

  localparam int DIV  = (25_000_000 + 8 * 115_200) / (16 * 115_200);
  localparam int BITC = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       out_ready_a = 1'b0, out_ready_b = 1'b0;
  logic       clear_a = 1'b0, clear_b = 1'b0;
  logic       out_valid_a, perr_a, ferr_a, break_a, overrun_a, rx_busy_a;
  logic       out_valid_b, perr_b, ferr_b, break_b, overrun_b, rx_busy_b;
  logic [7:0] data_a;
  logic [6:0] data_b;

  int          total = 0;
  int          bad = 0;
  int          rise_cyc;
  logic [11:0] exp_q[$];

  always #20 clk = ~clk;

  rs232in_fifo u_a (
    .clk25MHz(clk), .reset_n(reset_n), .serial_rxd(rxd_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .data(data_a),
    .parity_error(perr_a), .framing_error(ferr_a), .break_detect(break_a),
    .overrun(overrun_a), .clear_overrun(clear_a), .rx_busy(rx_busy_a)
  );

  rs232in_fifo #(.DATA_BITS(7), .PARITY(2)) u_b (
    .clk25MHz(clk), .reset_n(reset_n), .serial_rxd(rxd_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .data(data_b),
    .parity_error(perr_b), .framing_error(ferr_b), .break_detect(break_b),
    .overrun(overrun_b), .clear_overrun(clear_b), .rx_busy(rx_busy_b)
  );

  // Serial frame bits, LSB = start bit; remaining positions idle high
  function automatic logic [15:0] mk_frame(input int d, input int db, input int pmode,
                                           input int pbit, input int nstop, input logic stopv,
                                           output int n);
    logic [15:0] f;
    int k;
    f = 16'hFFFF;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < db; i++) begin f[k] = d[i]; k++; end
    if (pmode != 0) begin f[k] = pbit[0]; k++; end
    for (int i = 0; i < nstop; i++) begin f[k] = stopv; k++; end
    n = k;
    return f;
  endfunction

  // Expected entry {break, framing, parity, 9-bit data} from the frame's contents
  function automatic logic [11:0] model_entry(input int d, input int db, input int pmode,
                                              input int pbit, input logic stopv);
    int   dm, ones;
    logic perr, ferr, brk;
    dm   = d % (1 << db);
    ones = $countones(dm) + pbit;
    perr = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    ferr = ~stopv;
    brk  = (dm == 0) && (pbit == 0) && ferr;
    return {brk, ferr, perr, dm[8:0]};
  endfunction

  task automatic send_frame(input bit sel, input logic [15:0] bits, input int nbits);
    logic was, now;
    rise_cyc = -1;
    was = sel ? out_valid_b : out_valid_a;
    for (int c = 0; c < nbits * BITC; c++) begin
      if (sel) rxd_b = bits[c / BITC]; else rxd_a = bits[c / BITC];
      @(negedge clk);
      now = sel ? out_valid_b : out_valid_a;
      if (rise_cyc < 0 && !was && now) rise_cyc = c + 1;
      was = now;
    end
  endtask

  task automatic idle(input int n);
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_a(output logic v, output logic [11:0] e);
    v = out_valid_a;
    e = {break_a, ferr_a, perr_a, 1'b0, data_a};
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
  endtask

  task automatic pop_b(output logic v, output logic [11:0] e);
    v = out_valid_b;
    e = {break_b, ferr_b, perr_b, 2'b00, data_b};
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] oa;
    logic [12:0] ob;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    oa = {out_valid_a, rx_busy_a, overrun_a, break_a, ferr_a, perr_a, data_a};
    ob = {out_valid_b, rx_busy_b, overrun_b, break_b, ferr_b, perr_b, data_b};
    total++; if (oa !== 14'h0) begin bad++; $display("FAIL reset_a: got %h want 0", oa); end
    total++; if (ob !== 13'h0) begin bad++; $display("FAIL reset_b: got %h want 0", ob); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    oa = {out_valid_a, rx_busy_a, overrun_a, break_a, ferr_a, perr_a, data_a};
    total++; if (oa !== 14'h0) begin bad++; $display("FAIL post_reset_a: got %h want 0", oa); end
  endtask

  task automatic test_basic;
    int d[2] = '{8'h55, 8'hA3};
    int n, lat;
    logic [15:0] f;
    logic [11:0] e, ex;
    logic v;
    for (int i = 0; i < 2; i++) begin
      f  = mk_frame(d[i], 8, 0, 0, 1, 1'b1, n);
      ex = model_entry(d[i], 8, 0, 0, 1'b1);
      lat = 3 + DIV * (16 * (n - 1) + 10);
      send_frame(0, f, n);
      total++;
      if (rise_cyc < lat - 2 || rise_cyc > lat + 2) begin
        bad++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, rise_cyc, lat);
      end
      pop_a(v, e);
      total++;
      if (!v || e !== ex) begin bad++; $display("FAIL basic_entry[%0d]: got %b/%h want 1/%h", i, v, e, ex); end
      total++;
      if (out_valid_a !== 1'b0) begin bad++; $display("FAIL basic_empty[%0d]: got %b want 0", i, out_valid_a); end
    end
  endtask

  task automatic test_false_start;
    rxd_a = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rxd_a = 1'b1;
    total++; if (rx_busy_a !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %b want 1", rx_busy_a); end
    repeat (17 * DIV) @(negedge clk);
    total++;
    if ({rx_busy_a, out_valid_a} !== 2'b00) begin
      bad++; $display("FAIL glitch_idle: got %b want 00", {rx_busy_a, out_valid_a});
    end
  endtask

  task automatic test_parity;
    int n, d, p;
    logic [15:0] f;
    logic [11:0] e, ex;
    logic v;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8'h41 : $urandom_range(0, 127);
      p = (i == 0) ? 1 : ($countones(d) % 2);
      f  = mk_frame(d, 7, 2, p, 1, 1'b1, n);
      ex = model_entry(d, 7, 2, p, 1'b1);
      send_frame(1, f, n);
      idle(8);
      pop_b(v, e);
      total++;
      if (!v || e !== ex) begin bad++; $display("FAIL parity_entry[%0d]: got %b/%h want 1/%h", i, v, e, ex); end
    end
  endtask

  task automatic test_break;
    logic [11:0] e, ex;
    logic v;
    ex = model_entry(0, 8, 0, 0, 1'b0);
    rxd_a = 1'b0;
    repeat (20 * BITC) @(negedge clk);
    idle(2 * BITC);
    pop_a(v, e);
    total++; if (!v || e !== ex) begin bad++; $display("FAIL break_entry: got %b/%h want 1/%h", v, e, ex); end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL break_single: got %b want 0", out_valid_a); end
  endtask

  task automatic test_overrun;
    int n, d;
    logic [15:0] f;
    logic [11:0] e, ex;
    logic v;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      d = $urandom_range(0, 255);
      f = mk_frame(d, 8, 0, 0, 1, 1'b1, n);
      if (exp_q.size() < 16) exp_q.push_back(model_entry(d, 8, 0, 0, 1'b1));
      send_frame(0, f, n);
      if (i == 15) begin
        total++; if (overrun_a !== 1'b0) begin bad++; $display("FAIL overrun_early: got %b want 0", overrun_a); end
      end
    end
    total++; if (overrun_a !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun_a); end
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    total++; if (overrun_a !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun_a); end
    for (int i = 0; i < 16; i++) begin
      ex = exp_q.pop_front();
      pop_a(v, e);
      total++;
      if (!v || e !== ex) begin bad++; $display("FAIL overrun_pop[%0d]: got %b/%h want 1/%h", i, v, e, ex); end
    end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL overrun_drained: got %b want 0", out_valid_a); end
  endtask

  task automatic test_random;
    int n, d, k;
    logic stopv;
    logic [15:0] f;
    logic [11:0] e, ex;
    logic v;
    exp_q.delete();
    k = 0;
    for (int i = 0; i < 5; i++) begin
      d = $urandom_range(0, 255);
      stopv = ($urandom_range(0, 3) != 0);
      f = mk_frame(d, 8, 0, 0, 1, stopv, n);
      exp_q.push_back(model_entry(d, 8, 0, 0, stopv));
      send_frame(0, f, n);
      idle(BITC);
      if ($urandom_range(0, 1) == 1) begin
        ex = exp_q.pop_front();
        pop_a(v, e);
        total++;
        if (!v || e !== ex) begin bad++; $display("FAIL random_pop[%0d]: got %b/%h want 1/%h", k, v, e, ex); end
        k++;
      end
    end
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      pop_a(v, e);
      total++;
      if (!v || e !== ex) begin bad++; $display("FAIL random_drain[%0d]: got %b/%h want 1/%h", k, v, e, ex); end
      k++;
    end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL random_empty: got %b want 0", out_valid_a); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [15:0] f;
    logic [13:0] oa;
    logic [11:0] e, ex;
    logic v;
    f = mk_frame(8'h33, 8, 0, 0, 1, 1'b1, n);
    send_frame(0, f, n);
    f = mk_frame(8'h5A, 8, 0, 0, 1, 1'b1, n);
    send_frame(0, f, 4);
    total++;
    if ({out_valid_a, rx_busy_a} !== 2'b11) begin
      bad++; $display("FAIL midframe_state: got %b want 11", {out_valid_a, rx_busy_a});
    end
    reset_n = 1'b0;
    #1;
    oa = {out_valid_a, rx_busy_a, overrun_a, break_a, ferr_a, perr_a, data_a};
    total++; if (oa !== 14'h0) begin bad++; $display("FAIL midframe_reset: got %h want 0", oa); end
    @(negedge clk);
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2 * BITC);
    ex = model_entry(8'h5A, 8, 0, 0, 1'b1);
    send_frame(0, f, n);
    pop_a(v, e);
    total++; if (!v || e !== ex) begin bad++; $display("FAIL after_reset_entry: got %b/%h want 1/%h", v, e, ex); end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL after_reset_empty: got %b want 0", out_valid_a); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_break();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
